xsim_dma_burst_adapter: RTL and testbench

- Converts burst DMA requests (handle, base address, beat count) from the simulated memory-client logic into the single-word 32-bit read/write interface of the Xsim DMA read/write bridge.
- Sits directly upstream of the bridge. Its read-request, read-response and write32 ports connect one-to-one to the bridge's ports.
- The read engine and the write engine are independent and may run concurrently.

---
 rtl/xsim_dma_burst_adapter_if.sv | 62 ++++++
 rtl/xsim_dma_burst_adapter.sv | 148 ++++++++++++++
 tb/tb_xsim_dma_burst_adapter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xsim_dma_burst_adapter_if.sv
// Handshake and bus signals between the burst client, the adapter and the Xsim DMA bridge.
// The slave modport is the adapter's view. The master modport is the client/bridge view.
interface xsim_dma_burst_adapter_if #(
    parameter int LENW = 16
);
    logic            rdy_rdreq;
    logic            en_rdreq;
    logic [31:0]     rdreq_handle;
    logic [31:0]     rdreq_addr;
    logic [LENW-1:0] rdreq_len;
    logic            rdy_rd_data;
    logic            en_rd_data;
    logic [31:0]     rd_data;
    logic            rd_last;
    logic            rd_done;

    logic            rdy_wrreq;
    logic            en_wrreq;
    logic [31:0]     wrreq_handle;
    logic [31:0]     wrreq_addr;
    logic [LENW-1:0] wrreq_len;
    logic            rdy_wrdata;
    logic            en_wrdata;
    logic [31:0]     wrdata;
    logic [3:0]      wrdata_byteenable;
    logic            wr_done;

    logic            rdy_readrequest;
    logic            en_readrequest;
    logic [31:0]     readrequest_addr;
    logic [31:0]     readrequest_handle;
    logic            rdy_readresponse;
    logic            en_readresponse;
    logic [31:0]     readresponse_data;
    logic            en_write32;
    logic [31:0]     write32_addr;
    logic [31:0]     write32_handle;
    logic [31:0]     write32_data;
    logic [3:0]      write32_byteenable;

    modport slave (
        output rdy_rdreq, rdy_rd_data, rd_data, rd_last, rd_done,
        output rdy_wrreq, rdy_wrdata, wr_done,
        output en_readrequest, readrequest_addr, readrequest_handle, en_readresponse,
        output en_write32, write32_addr, write32_handle, write32_data, write32_byteenable,
        input  en_rdreq, rdreq_handle, rdreq_addr, rdreq_len, en_rd_data,
        input  en_wrreq, wrreq_handle, wrreq_addr, wrreq_len,
        input  en_wrdata, wrdata, wrdata_byteenable,
        input  rdy_readrequest, rdy_readresponse, readresponse_data
    );

    modport master (
        input  rdy_rdreq, rdy_rd_data, rd_data, rd_last, rd_done,
        input  rdy_wrreq, rdy_wrdata, wr_done,
        input  en_readrequest, readrequest_addr, readrequest_handle, en_readresponse,
        input  en_write32, write32_addr, write32_handle, write32_data, write32_byteenable,
        output en_rdreq, rdreq_handle, rdreq_addr, rdreq_len, en_rd_data,
        output en_wrreq, wrreq_handle, wrreq_addr, wrreq_len,
        output en_wrdata, wrdata, wrdata_byteenable,
        output rdy_readrequest, rdy_readresponse, readresponse_data
    );
endinterface

// File: rtl/xsim_dma_burst_adapter.sv
// Splits burst read/write requests into single-word bridge transactions.
// The read engine and the write engine are independent and run concurrently.
//
// state  | meaning
// IDLE   | engine ready for a new burst request
// BUSY   | read: issuing requests / returning beats; write: accepting beats
module xsim_dma_burst_adapter #(
    parameter int LENW   = 16,
    parameter int STRIDE = 4
) (
    input logic CLK,
    input logic RST,
    xsim_dma_burst_adapter_if.slave bus
);
    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_BUSY   = 1'b1;
    localparam logic [31:0] STRIDE_W = 32'(STRIDE);

    logic [0:0]      rd_state;
    logic [31:0]     rd_handle;
    logic [31:0]     rd_base;
    logic [LENW-1:0] rd_len;
    logic [LENW-1:0] issue_cnt;
    logic [LENW-1:0] recv_cnt;
    logic [31:0]     rd_data_q;
    logic            rd_valid;
    logic            rd_last_q;
    logic            rd_done_q;
    logic            rd_issue;
    logic            rd_take;
    logic            rd_deq;

    // The recv_cnt guard keeps a stray response from landing after the last beat.
    assign rd_issue = !RST && (rd_state == S_BUSY) && (issue_cnt != rd_len) && bus.rdy_readrequest;
    assign rd_take  = !RST && (rd_state == S_BUSY) && (recv_cnt != rd_len) && bus.rdy_readresponse
                      && (!rd_valid || bus.en_rd_data);
    assign rd_deq   = rd_valid && bus.en_rd_data;

    assign bus.rdy_rdreq          = (rd_state == S_IDLE);
    assign bus.en_readrequest     = rd_issue;
    assign bus.readrequest_addr   = rd_base + STRIDE_W * 32'(issue_cnt);
    assign bus.readrequest_handle = rd_handle;
    assign bus.en_readresponse    = rd_take;
    assign bus.rdy_rd_data        = rd_valid;
    assign bus.rd_data            = rd_data_q;
    assign bus.rd_last            = rd_last_q;
    assign bus.rd_done            = rd_done_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_state  <= S_IDLE;
            rd_handle <= '0;
            rd_base   <= '0;
            rd_len    <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            rd_data_q <= '0;
            rd_valid  <= 1'b0;
            rd_last_q <= 1'b0;
            rd_done_q <= 1'b0;
        end else begin
            rd_done_q <= 1'b0;
            case (rd_state)
                S_IDLE: begin
                    if (bus.en_rdreq) begin
                        rd_handle <= bus.rdreq_handle;
                        rd_base   <= bus.rdreq_addr;
                        rd_len    <= bus.rdreq_len;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        if (bus.rdreq_len == '0) rd_done_q <= 1'b1;
                        else                     rd_state  <= S_BUSY;
                    end
                end
                default: begin
                    if (rd_issue) issue_cnt <= issue_cnt + LENW'(1);
                    // A take in the same cycle as a dequeue overwrites the held beat.
                    if (rd_take) begin
                        rd_data_q <= bus.readresponse_data;
                        rd_valid  <= 1'b1;
                        rd_last_q <= (recv_cnt == rd_len - LENW'(1));
                        recv_cnt  <= recv_cnt + LENW'(1);
                    end else if (rd_deq) begin
                        rd_valid  <= 1'b0;
                        rd_last_q <= 1'b0;
                    end
                    if (rd_deq && rd_last_q) begin
                        rd_state  <= S_IDLE;
                        rd_done_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    logic [0:0]      wr_state;
    logic [31:0]     wr_handle;
    logic [31:0]     wr_base;
    logic [LENW-1:0] wr_len;
    logic [LENW-1:0] wr_cnt;
    logic            wr_done_q;
    logic            wr_beat;

    assign wr_beat = !RST && (wr_state == S_BUSY) && bus.en_wrdata;

    assign bus.rdy_wrreq          = (wr_state == S_IDLE);
    assign bus.rdy_wrdata         = (wr_state == S_BUSY);
    assign bus.en_write32         = wr_beat;
    assign bus.write32_addr       = wr_base + STRIDE_W * 32'(wr_cnt);
    assign bus.write32_handle     = wr_handle;
    assign bus.write32_data       = bus.wrdata;
    assign bus.write32_byteenable = bus.wrdata_byteenable;
    assign bus.wr_done            = wr_done_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_state  <= S_IDLE;
            wr_handle <= '0;
            wr_base   <= '0;
            wr_len    <= '0;
            wr_cnt    <= '0;
            wr_done_q <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            case (wr_state)
                S_IDLE: begin
                    if (bus.en_wrreq) begin
                        wr_handle <= bus.wrreq_handle;
                        wr_base   <= bus.wrreq_addr;
                        wr_len    <= bus.wrreq_len;
                        wr_cnt    <= '0;
                        if (bus.wrreq_len == '0) wr_done_q <= 1'b1;
                        else                     wr_state  <= S_BUSY;
                    end
                end
                default: begin
                    if (wr_beat) begin
                        wr_cnt <= wr_cnt + LENW'(1);
                        if (wr_cnt == wr_len - LENW'(1)) begin
                            wr_state  <= S_IDLE;
                            wr_done_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_xsim_dma_burst_adapter.sv
// Scoreboard bench for the DMA burst adapter with a one-outstanding bridge model
// that answers each read request with addr + 0xA000.
module tb_xsim_dma_burst_adapter;
    localparam int LENW = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    xsim_dma_burst_adapter_if #(.LENW(LENW)) bus();

    xsim_dma_burst_adapter #(.LENW(LENW), .STRIDE(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] hndl;
        logic [3:0]  be;
        logic        last;
    } exp_t;

    exp_t rreq_q[$];
    exp_t rdat_q[$];
    exp_t wr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, rd_end_cyc = -100, wr_end_cyc = -100;
    int rd_done_cnt = 0, wr_done_cnt = 0, req_total = 0, wr_total = 0;
    logic        req_fire = 1'b0, resp_fire = 1'b0, rst_s = 1'b1;
    logic [31:0] req_addr_s = '0;

    logic [31:0] wdat[4];
    logic [3:0]  wbe[4];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: samples mid-cycle, compares against the scoreboard queues.
    initial forever begin
        exp_t e;
        @(negedge CLK);
        cyc++;
        rst_s      = RST;
        req_fire   = bus.en_readrequest;
        resp_fire  = bus.en_readresponse;
        req_addr_s = bus.readrequest_addr;
        if (bus.rd_done) begin
            rd_done_cnt++;
            check_val("rd_done_lat", cyc - rd_end_cyc, 1);
            check_val("rd_done_rdy", {31'b0, bus.rdy_rdreq}, 1);
        end
        if (bus.wr_done) begin
            wr_done_cnt++;
            check_val("wr_done_lat", cyc - wr_end_cyc, 1);
            check_val("wr_done_rdy", {31'b0, bus.rdy_wrreq}, 1);
        end
        if (bus.en_readrequest) begin
            req_total++;
            if (rreq_q.size() == 0) check_val("rreq_q_size", rreq_q.size(), 1);
            else begin
                e = rreq_q.pop_front();
                check_val("rreq_addr", bus.readrequest_addr, e.addr);
                check_val("rreq_handle", bus.readrequest_handle, e.hndl);
            end
        end
        if (!RST && bus.rdy_rd_data && !bus.en_rd_data)
            check_val("hold_no_take", {31'b0, bus.en_readresponse}, 0);
        if (bus.rdy_rd_data && bus.en_rd_data) begin
            if (rdat_q.size() == 0) check_val("rdat_q_size", rdat_q.size(), 1);
            else begin
                e = rdat_q.pop_front();
                check_val("rd_data", bus.rd_data, e.data);
                check_val("rd_last", {31'b0, bus.rd_last}, {31'b0, e.last});
                if (e.last) rd_end_cyc = cyc;
            end
        end
        if (bus.en_write32) begin
            wr_total++;
            if (wr_q.size() == 0) check_val("wr_q_size", wr_q.size(), 1);
            else begin
                e = wr_q.pop_front();
                check_val("w32_addr", bus.write32_addr, e.addr);
                check_val("w32_handle", bus.write32_handle, e.hndl);
                check_val("w32_data", bus.write32_data, e.data);
                check_val("w32_be", {28'b0, bus.write32_byteenable}, {28'b0, e.be});
                if (e.last) wr_end_cyc = cyc;
            end
        end
        if (!RST && bus.en_rdreq && bus.rdy_rdreq && bus.rdreq_len == '0) rd_end_cyc = cyc;
        if (!RST && bus.en_wrreq && bus.rdy_wrreq && bus.wrreq_len == '0) wr_end_cyc = cyc;
        if (RST) begin
            rd_end_cyc = -100;
            wr_end_cyc = -100;
        end
    end

    // Bridge model: at most one outstanding read response.
    initial forever begin
        @(posedge CLK);
        #1;
        if (rst_s) begin
            bus.rdy_readresponse = 1'b0;
        end else begin
            if (resp_fire) bus.rdy_readresponse = 1'b0;
            if (req_fire) begin
                bus.rdy_readresponse  = 1'b1;
                bus.readresponse_data = req_addr_s + 32'hA000;
            end
        end
        bus.rdy_readrequest = !bus.rdy_readresponse;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd_req(input logic [31:0] h, input logic [31:0] a, input int len);
        exp_t e;
        for (int i = 0; i < 200 && !bus.rdy_rdreq; i++) step();
        check_val("rdy_rdreq", {31'b0, bus.rdy_rdreq}, 1);
        bus.en_rdreq     = 1'b1;
        bus.rdreq_handle = h;
        bus.rdreq_addr   = a;
        bus.rdreq_len    = LENW'(len);
        for (int i = 0; i < len; i++) begin
            e.addr = a + 32'(4 * i);
            e.hndl = h;
            e.data = e.addr + 32'hA000;
            e.be   = 4'h0;
            e.last = (i == len - 1);
            rreq_q.push_back(e);
            rdat_q.push_back(e);
        end
        step();
        bus.en_rdreq = 1'b0;
    endtask

    task automatic wr_burst(input logic [31:0] h, input logic [31:0] a, input int len);
        exp_t e;
        for (int i = 0; i < 200 && !bus.rdy_wrreq; i++) step();
        bus.en_wrreq     = 1'b1;
        bus.wrreq_handle = h;
        bus.wrreq_addr   = a;
        bus.wrreq_len    = LENW'(len);
        step();
        bus.en_wrreq = 1'b0;
        for (int i = 0; i < len; i++) begin
            check_val("rdy_wrdata", {31'b0, bus.rdy_wrdata}, 1);
            bus.en_wrdata         = 1'b1;
            bus.wrdata            = wdat[i];
            bus.wrdata_byteenable = wbe[i];
            e.addr = a + 32'(4 * i);
            e.hndl = h;
            e.data = wdat[i];
            e.be   = wbe[i];
            e.last = (i == len - 1);
            wr_q.push_back(e);
            step();
        end
        bus.en_wrdata = 1'b0;
    endtask

    task automatic wait_rd(input int target);
        for (int i = 0; i < 300 && rd_done_cnt < target; i++) step();
        check_val("rd_done_cnt", rd_done_cnt, target);
    endtask

    task automatic wait_wr(input int target);
        for (int i = 0; i < 300 && wr_done_cnt < target; i++) step();
        check_val("wr_done_cnt", wr_done_cnt, target);
    endtask

    initial begin
        int req0, wr0;
        bus.en_rdreq = 1'b0;  bus.rdreq_handle = '0; bus.rdreq_addr = '0; bus.rdreq_len = '0;
        bus.en_rd_data = 1'b1;
        bus.en_wrreq = 1'b0;  bus.wrreq_handle = '0; bus.wrreq_addr = '0; bus.wrreq_len = '0;
        bus.en_wrdata = 1'b0; bus.wrdata = '0; bus.wrdata_byteenable = '0;
        bus.rdy_readrequest = 1'b1; bus.rdy_readresponse = 1'b0; bus.readresponse_data = '0;
        wdat = '{32'h11, 32'h22, 32'h33, 32'h44};
        wbe  = '{4'hF, 4'h3, 4'hC, 4'h1};

        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        check_val("rst_rdy_rdreq", {31'b0, bus.rdy_rdreq}, 1);
        check_val("rst_rdy_wrreq", {31'b0, bus.rdy_wrreq}, 1);
        check_val("rst_rdy_rd_data", {31'b0, bus.rdy_rd_data}, 0);
        check_val("rst_rd_last", {31'b0, bus.rd_last}, 0);
        check_val("rst_rd_done", {31'b0, bus.rd_done}, 0);
        check_val("rst_wr_done", {31'b0, bus.wr_done}, 0);
        check_val("rst_rd_data", bus.rd_data, 0);
        check_val("rst_rdy_wrdata", {31'b0, bus.rdy_wrdata}, 0);

        // Basic read burst
        rd_req(32'd5, 32'h100, 3);
        wait_rd(1);

        // Consumer backpressure after the first beat
        bus.en_rd_data = 1'b0;
        rd_req(32'd7, 32'h500, 4);
        for (int i = 0; i < 100 && !bus.rdy_rd_data; i++) step();
        repeat (6) step();
        bus.en_rd_data = 1'b1;
        wait_rd(2);

        // Write burst with a concurrent read burst
        rd_req(32'd9, 32'h600, 2);
        wr_burst(32'd3, 32'h200, 4);
        wait_rd(3);
        wait_wr(1);

        // Zero-length read and write accepted together
        req0 = req_total;
        wr0  = wr_total;
        bus.en_rdreq = 1'b1; bus.rdreq_len = '0; bus.rdreq_addr = 32'h700;
        bus.en_wrreq = 1'b1; bus.wrreq_len = '0; bus.wrreq_addr = 32'h800;
        step();
        bus.en_rdreq = 1'b0;
        bus.en_wrreq = 1'b0;
        wait_rd(4);
        wait_wr(2);
        repeat (4) step();
        check_val("zero_no_rreq", req_total - req0, 0);
        check_val("zero_no_w32", wr_total - wr0, 0);

        // Address wrap past 2^32
        rd_req(32'd1, 32'hFFFF_FFF8, 4);
        wait_rd(5);

        // Reset after two of five beats
        bus.en_rd_data = 1'b0;
        rd_req(32'd2, 32'h300, 5);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 100 && !bus.rdy_rd_data; i++) step();
            bus.en_rd_data = 1'b1;
            step();
            bus.en_rd_data = 1'b0;
        end
        RST = 1'b1;
        rreq_q.delete();
        rdat_q.delete();
        step();
        RST = 1'b0;
        check_val("mid_rst_rdy_rd_data", {31'b0, bus.rdy_rd_data}, 0);
        check_val("mid_rst_rdy_rdreq", {31'b0, bus.rdy_rdreq}, 1);
        repeat (5) step();
        check_val("mid_rst_no_done", rd_done_cnt, 5);
        bus.en_rd_data = 1'b1;
        rd_req(32'd4, 32'h40, 2);
        wait_rd(6);

        repeat (3) step();
        check_val("rreq_q_left", rreq_q.size(), 0);
        check_val("rdat_q_left", rdat_q.size(), 0);
        check_val("wr_q_left", wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
